// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions for the control unit and the encoder.
//   cuop_t   - operation codes emitted by the decoder, consumed by the encoder
//   fmt_t    - instruction layout selector used by the encoder
//   OPC_*    - major opcodes, F3_* / F7_* - function fields, NOP - addi x0,x0,0
//   fits_signed() - true when v is a sign-extension of its bits [msb:0]
package rv32_pkg;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } cuop_t;

    typedef enum logic [2:0] {
        FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R, FMT_BAD
    } fmt_t;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    // ALU / JALR
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    // branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    // load/store access width
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two (>=2).
//   push/wdata - write when not full, or when full and popping in the same cycle
//   pop/rdata  - rdata shows the head entry; pop on empty is ignored
//   empty/full - occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   used;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gates every read, so
    // stale words are never observable and the array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (used == '0);
    assign full  = (used == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I encoder, the inverse of the control/decode unit.
//   load_pc/base_pc  - reload the word-address counter (wins over increment)
//   in_valid/in_ready, op, rd, rs1, rs2, imm - operation to encode
//   out_valid/out_ready, instr, addr, err    - head of the output FIFO
//   count            - entries consumed since reset, saturating
// Build option: define RANGE_CHECK_EN to flag immediates the format cannot
// represent (NOP + err); otherwise immediates are truncated silently.
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] base_pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int ENTRY_W = 32 + ADDR_W + 1;

    fmt_t              fmt;
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic              imm_ok;
    logic [31:0]       enc_instr;
    logic              enc_err;
    logic [ADDR_W-1:0] pc;
    logic              accept, pop, fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] head;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_addr;
    logic              head_err;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        fmt = FMT_BAD;
        opc = '0;
        f3  = '0;
        f7  = F7_ZERO;
        case (op)
            OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;   end
            OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC; end
            OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;   end
            OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;  f3 = F3_ADD;  end
            OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BNE;  end
            OP_BLT:   begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BLT;  end
            OP_BGE:   begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BGE;  end
            OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = F3_BGEU; end
            OP_LB:    begin fmt = FMT_I;  opc = OPC_LD;    f3 = F3_B;    end
            OP_LH:    begin fmt = FMT_I;  opc = OPC_LD;    f3 = F3_H;    end
            OP_LW:    begin fmt = FMT_I;  opc = OPC_LD;    f3 = F3_W;    end
            OP_LBU:   begin fmt = FMT_I;  opc = OPC_LD;    f3 = F3_BU;   end
            OP_LHU:   begin fmt = FMT_I;  opc = OPC_LD;    f3 = F3_HU;   end
            OP_SB:    begin fmt = FMT_S;  opc = OPC_ST;    f3 = F3_B;    end
            OP_SH:    begin fmt = FMT_S;  opc = OPC_ST;    f3 = F3_H;    end
            OP_SW:    begin fmt = FMT_S;  opc = OPC_ST;    f3 = F3_W;    end
            OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_ADD;  end
            OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_SLTU; end
            OP_XORI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_XOR;  end
            OP_ORI:   begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_OR;   end
            OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = F3_AND;  end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SLL;  end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SR;   end
            OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SR;   f7 = F7_ALT; end
            OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_ADD;  end
            OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_ADD;  f7 = F7_ALT; end
            OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_SLL;  end
            OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_SLT;  end
            OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_SLTU; end
            OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_XOR;  end
            OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_SR;   end
            OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_SR;   f7 = F7_ALT; end
            OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_OR;   end
            OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = F3_AND;  end
            default:  fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        imm_ok = 1'b1;
`ifdef RANGE_CHECK_EN
        // Representable iff the bits above the field are a sign extension.
        case (fmt)
            FMT_I, FMT_S: imm_ok = fits_signed(imm, 11);
            FMT_B:        imm_ok = !imm[0] && fits_signed(imm, 12);
            FMT_J:        imm_ok = !imm[0] && fits_signed(imm, 20);
            FMT_U:        imm_ok = (imm[11:0] == '0);
            FMT_SH:       imm_ok = (imm[31:5] == '0);
            default:      imm_ok = 1'b1;
        endcase
`endif
    end

    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        case (fmt)
            FMT_U:   enc_instr = {imm[31:12], rd, opc};
            FMT_J:   enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            FMT_I:   enc_instr = {imm[11:0], rs1, f3, rd, opc};
            FMT_SH:  enc_instr = {f7, imm[4:0], rs1, f3, rd, opc};
            FMT_S:   enc_instr = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   enc_instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_R:   enc_instr = {f7, rs2, rs1, f3, rd, opc};
            default: enc_err   = 1'b1;
        endcase
        if (enc_err || !imm_ok) begin
            enc_instr = NOP;
            enc_err   = 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !fifo_full || pop;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            count <= '0;
        end else begin
            if (load_pc)     pc <= base_pc;
            else if (accept) pc <= pc + 1'b1;
            if (pop && count != '1) count <= count + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata ({enc_instr, pc, enc_err}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign {head_instr, head_addr, head_err} = head;

    // Outputs read as zero while empty so nothing stale leaks after reset.
    assign instr = out_valid ? head_instr : '0;
    assign addr  = out_valid ? head_addr  : '0;
    assign err   = out_valid && head_err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import rv32_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int FIFO_D  = 2;
    localparam int CNT_MAX = 2 ** (ADDR_W + 1) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_pc;
    logic [ADDR_W-1:0] base_pc;
    logic              in_valid, in_ready;
    logic [5:0]        op;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic              out_valid, out_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [ADDR_W:0]   count;

    instr_encoder #(.ADDR_W(ADDR_W), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .rst(rst), .load_pc(load_pc), .base_pc(base_pc),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .addr(addr), .err(err),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          addr;
        logic        err;
    } exp_t;

    typedef struct {
        int          op;
        int          rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];
    int   m_pc, m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder built from the field layouts with shifts and masks.
    function automatic exp_t model(input int opn, input logic [31:0] d, s1, s2, im);
        exp_t  e;
        byte   fmt;
        logic [31:0] opc, f3, f7, w;
        int    s;
        bit    ok;
        fmt = "X"; opc = 0; f3 = 0; f7 = 0; w = 0; ok = 1; s = $signed(im);
        case (opn)
            OP_LUI:   begin fmt = "U"; opc = 'h37; end
            OP_AUIPC: begin fmt = "U"; opc = 'h17; end
            OP_JAL:   begin fmt = "J"; opc = 'h6F; end
            OP_JALR:  begin fmt = "I"; opc = 'h67; end
            OP_BEQ:   begin fmt = "B"; opc = 'h63; f3 = 0; end
            OP_BNE:   begin fmt = "B"; opc = 'h63; f3 = 1; end
            OP_BLT:   begin fmt = "B"; opc = 'h63; f3 = 4; end
            OP_BGE:   begin fmt = "B"; opc = 'h63; f3 = 5; end
            OP_BLTU:  begin fmt = "B"; opc = 'h63; f3 = 6; end
            OP_BGEU:  begin fmt = "B"; opc = 'h63; f3 = 7; end
            OP_LB:    begin fmt = "I"; opc = 'h03; f3 = 0; end
            OP_LH:    begin fmt = "I"; opc = 'h03; f3 = 1; end
            OP_LW:    begin fmt = "I"; opc = 'h03; f3 = 2; end
            OP_LBU:   begin fmt = "I"; opc = 'h03; f3 = 4; end
            OP_LHU:   begin fmt = "I"; opc = 'h03; f3 = 5; end
            OP_SB:    begin fmt = "S"; opc = 'h23; f3 = 0; end
            OP_SH:    begin fmt = "S"; opc = 'h23; f3 = 1; end
            OP_SW:    begin fmt = "S"; opc = 'h23; f3 = 2; end
            OP_ADDI:  begin fmt = "I"; opc = 'h13; f3 = 0; end
            OP_SLTI:  begin fmt = "I"; opc = 'h13; f3 = 2; end
            OP_SLTIU: begin fmt = "I"; opc = 'h13; f3 = 3; end
            OP_XORI:  begin fmt = "I"; opc = 'h13; f3 = 4; end
            OP_ORI:   begin fmt = "I"; opc = 'h13; f3 = 6; end
            OP_ANDI:  begin fmt = "I"; opc = 'h13; f3 = 7; end
            OP_SLLI:  begin fmt = "H"; opc = 'h13; f3 = 1; end
            OP_SRLI:  begin fmt = "H"; opc = 'h13; f3 = 5; end
            OP_SRAI:  begin fmt = "H"; opc = 'h13; f3 = 5; f7 = 'h20; end
            OP_ADD:   begin fmt = "R"; opc = 'h33; f3 = 0; end
            OP_SUB:   begin fmt = "R"; opc = 'h33; f3 = 0; f7 = 'h20; end
            OP_SLL:   begin fmt = "R"; opc = 'h33; f3 = 1; end
            OP_SLT:   begin fmt = "R"; opc = 'h33; f3 = 2; end
            OP_SLTU:  begin fmt = "R"; opc = 'h33; f3 = 3; end
            OP_XOR:   begin fmt = "R"; opc = 'h33; f3 = 4; end
            OP_SRL:   begin fmt = "R"; opc = 'h33; f3 = 5; end
            OP_SRA:   begin fmt = "R"; opc = 'h33; f3 = 5; f7 = 'h20; end
            OP_OR:    begin fmt = "R"; opc = 'h33; f3 = 6; end
            OP_AND:   begin fmt = "R"; opc = 'h33; f3 = 7; end
            default:  fmt = "X";
        endcase
`ifdef RANGE_CHECK_EN
        case (fmt)
            "I", "S": ok = (s >= -2048) && (s <= 2047);
            "B":      ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
            "J":      ok = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
            "U":      ok = (im % 4096 == 0);
            "H":      ok = (im < 32);
            default:  ok = 1;
        endcase
`endif
        case (fmt)
            "U": w = (im & 32'hFFFF_F000) | (d << 7) | opc;
            "J": w = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3FF) << 21) |
                     (((im >> 11) & 1) << 20) | (((im >> 12) & 'hFF) << 12) | (d << 7) | opc;
            "I": w = ((im & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
            "H": w = (f7 << 25) | ((im & 31) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
            "S": w = (((im >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) |
                     ((im & 31) << 7) | opc;
            "B": w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3F) << 25) | (s2 << 20) |
                     (s1 << 15) | (f3 << 12) | (((im >> 1) & 'hF) << 8) |
                     (((im >> 11) & 1) << 7) | opc;
            "R": w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
            default: w = 0;
        endcase
        if (fmt == "X" || !ok) begin
            e.instr = 32'h13;
            e.err   = 1'b1;
        end else begin
            e.instr = w;
            e.err   = 1'b0;
        end
        e.addr = 0;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; load_pc = 0; base_pc = '0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        q.delete();
        m_pc = 0;
        m_count = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock of model-tracked operation: compare at the falling edge,
    // advance the model at the rising edge, return just after it.
    task automatic step();
        bit   mr;
        exp_t e;
        @(negedge clk);
        mr = (q.size() < FIFO_D) || (q.size() > 0 && out_ready);
        check("in_ready", 64'(in_ready), 64'(mr));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("instr", 64'(instr), 64'(q[0].instr));
            check("addr", 64'(addr), 64'(q[0].addr));
            check("err", 64'(err), 64'(q[0].err));
        end
        check("count", 64'(count), 64'(m_count));
        @(posedge clk);
        if (out_ready && q.size() > 0) begin
            void'(q.pop_front());
            if (m_count < CNT_MAX) m_count++;
        end
        if (in_valid && mr) begin
            e = model(int'(op), 32'(rd), 32'(rs1), 32'(rs2), imm);
            e.addr = m_pc;
            q.push_back(e);
        end
        if (load_pc) m_pc = int'(base_pc);
        else if (in_valid && mr) m_pc = (m_pc + 1) % (2 ** ADDR_W);
        #1;
    endtask

    task automatic drive(input int o, input int d, input int a, input int b, input logic [31:0] i);
        op = 6'(o); rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b); imm = i;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{OP_LUI,   10,  0,  0, 32'hAAAAA000, 32'hAAAAA537, 1'b0};
        vecs[1]  = '{OP_ADD,   24, 10, 12, 32'h0,        32'h00C50C33, 1'b0};
        vecs[2]  = '{OP_SUB,   24, 10, 12, 32'h0,        32'h40C50C33, 1'b0};
        vecs[3]  = '{OP_ADDI,  26, 10,  0, -32'sd1348,   32'hABC50D13, 1'b0};
        vecs[4]  = '{OP_LW,    10, 21,  0, -32'sd1348,   32'hABCAA503, 1'b0};
        vecs[5]  = '{OP_JAL,    1,  0,  0, 32'd2048,     32'h001000EF, 1'b0};
        vecs[6]  = '{OP_BEQ,    0,  1,  2, -32'sd4,      32'hFE208EE3, 1'b0};
        vecs[7]  = '{OP_SW,     0,  2,  5, 32'd8,        32'h00512423, 1'b0};
        vecs[8]  = '{OP_SRAI,   3,  4,  0, 32'd7,        32'h40725193, 1'b0};
        vecs[9]  = '{63,        5,  6,  7, 32'd100,      32'h00000013, 1'b1};
`ifdef RANGE_CHECK_EN
        vecs[10] = '{OP_ADDI,   0,  0,  0, 32'd4096,     32'h00000013, 1'b1};
`else
        vecs[10] = '{OP_ADDI,   0,  0,  0, 32'd4096,     32'h00000013, 1'b0};
`endif

        // Reset state, observed while reset is still asserted.
        rst = 1'b1;
        in_valid = 0; out_ready = 0; load_pc = 0; base_pc = '0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        #12;
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst instr", 64'(instr), 64'(0));
        check("rst addr", 64'(addr), 64'(0));
        check("rst err", 64'(err), 64'(0));
        check("rst count", 64'(count), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(1));

        // Known encodings, one per cycle, each visible the cycle after accept.
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1;
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            @(posedge clk);
            #1 in_valid = 0;
            check($sformatf("vec%0d valid", i), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d instr", i), 64'(instr), 64'(vecs[i].instr));
            check($sformatf("vec%0d addr", i), 64'(addr), 64'(i));
            check($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].err));
        end
        @(posedge clk);
        #1;
        check("vec count", 64'(count), 64'(11));
        check("vec drained", 64'(out_valid), 64'(0));

        // Backpressure: two fill the FIFO, third waits, then all drain in order.
        do_reset();
        in_valid = 1;
        drive(OP_ADD, 24, 10, 12, 0);           step();
        drive(OP_SUB, 24, 10, 12, 0);           step();
        check("bp full in_ready", 64'(in_ready), 64'(0));
        drive(OP_LUI, 10, 0, 0, 32'hAAAAA000);  step();
        check("bp head still A", 64'(instr), 64'(32'h00C50C33));
        out_ready = 1;                          step();
        check("bp head B", 64'(instr), 64'(32'h40C50C33));
        in_valid = 0;                           step();
        check("bp head C", 64'(instr), 64'(32'hAAAAA537));
        check("bp head C addr", 64'(addr), 64'(2));
        step();
        check("bp count", 64'(count), 64'(3));
        check("bp empty", 64'(out_valid), 64'(0));

        // Address wrap and load_pc coinciding with an accept.
        do_reset();
        out_ready = 1;
        load_pc = 1; base_pc = 10'd1023;        step();
        load_pc = 0; in_valid = 1;
        drive(OP_ADDI, 1, 2, 0, 5);             step();
        check("wrap addr 1023", 64'(addr), 64'(1023));
        step();
        check("wrap addr 0", 64'(addr), 64'(0));
        load_pc = 1; base_pc = 10'd5;           step();
        check("load+accept old pc", 64'(addr), 64'(1));
        load_pc = 0;                            step();
        check("load+accept new pc", 64'(addr), 64'(5));
        in_valid = 0;                           step();

        // Asynchronous reset with a full FIFO drops everything at once.
        do_reset();
        in_valid = 1;
        drive(OP_ADD, 1, 2, 3, 0);              step();
        step();
        in_valid = 0;
        #3 rst = 1'b1;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'(0));
        check("midrst instr", 64'(instr), 64'(0));
        check("midrst in_ready", 64'(in_ready), 64'(1));

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load_pc   = ($urandom_range(0, 31) == 0);
            base_pc   = ADDR_W'($urandom);
            op = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 39));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = 32'($urandom_range(0, 63));
                3: imm = $urandom & 32'hFFFF_F000;
                default: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
            endcase
            step();
        end
        in_valid = 0; load_pc = 0; out_ready = 1;
        repeat (4) step();

        // Count saturation at all-ones.
        do_reset();
        in_valid = 1; out_ready = 1;
        drive(OP_ADDI, 1, 1, 0, 1);
        repeat (CNT_MAX + 60) step();
        check("count saturated", 64'(count), 64'(CNT_MAX));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
